// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED chain shift-out engine:
//   - ledState_e : row sequencer states
//   - TLC5955 defaults (channels per chip, grayscale width, control bit value)
//   - rowCycles(): cycles from the sampled cmdStart to the cmdDone pulse
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CTRL_LO = 3'd2,
    CTRL_HI = 3'd3,
    BIT_LO  = 3'd4,
    BIT_HI  = 3'd5,
    LATCH   = 3'd6,
    DONE    = 3'd7
  } ledState_e;

  localparam int   TLC_CH_PER_CHIP = 48;
  localparam int   TLC_GS_BITS     = 16;
  localparam logic TLC_CTRL_BIT    = 1'b0;

  // One cycle to leave IDLE, two cycles per shifted bit (control bits
  // included), RD latency per fetched word and the LAT pulse width.
  function automatic int rowCycles(input int chainLen, input int chPerChip,
                                   input int gsBits, input int rdLatency,
                                   input int latCycles);
    int words;
    int bitsPerLane;
    words       = chainLen * chPerChip;
    bitsPerLane = chainLen * (1 + chPerChip * gsBits);
    return 1 + 2 * bitsPerLane + words * rdLatency + latCycles;
  endfunction

endpackage

// File: rtl/led_chain_shifter_chk.sv
// ---------------------------------------------------------------------------
// led_chain_shifter_chk
// Protocol checker for led_chain_shifter: SCLK and LAT never overlap, and
// cmdDone arrives exactly rowCycles() cycles after an accepted cmdStart.
// Ports: spiClk, nReset, cmdStart, busy, cmdDone, SCLK, LAT (all observed).
// ---------------------------------------------------------------------------
module led_chain_shifter_chk
  import led_pkg::*;
#(
  parameter int CHAIN_LEN   = 2,
  parameter int CH_PER_CHIP = TLC_CH_PER_CHIP,
  parameter int GS_BITS     = TLC_GS_BITS,
  parameter int RD_LATENCY  = 1,
  parameter int LAT_CYCLES  = 2
) (
  input logic spiClk,
  input logic nReset,
  input logic cmdStart,
  input logic busy,
  input logic cmdDone,
  input logic SCLK,
  input logic LAT
);

  localparam int ROW_CYCLES = rowCycles(CHAIN_LEN, CH_PER_CHIP, GS_BITS,
                                        RD_LATENCY, LAT_CYCLES);

  logic running_r;
  int   cycleCnt_r;

  // Row length tracking plus pin-level invariants.
  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      running_r  <= 1'b0;
      cycleCnt_r <= 32'sd0;
    end else begin
      assert (!(SCLK && LAT));
      if (cmdDone) begin
        assert (running_r && (cycleCnt_r == ROW_CYCLES));
      end
      if (running_r) begin
        running_r  <= !cmdDone;
        cycleCnt_r <= cycleCnt_r + 32'sd1;
      end else if (cmdStart && !busy) begin
        running_r  <= 1'b1;
        cycleCnt_r <= 32'sd1;
      end else begin
        cycleCnt_r <= 32'sd0;
      end
    end
  end

endmodule

// File: rtl/led_lane_sreg.sv
// ---------------------------------------------------------------------------
// led_lane_sreg
// One lane of grayscale data: GS_BITS parallel-load, MSB-first shift register
// that also owns the registered SDO pin bit of its lane.
// Ports:
//   spiClk, nReset : clock, synchronous active-low reset
//   load           : capture din (takes priority over shift)
//   shift          : shift left by one, zero fill
//   sdoEn          : next cycle is a data bit; drive MSB of the next contents
//   ctrlEn         : next cycle is a control bit; drive the control value
//   din            : parallel load word
//   sdo            : registered serial output
// ---------------------------------------------------------------------------
module led_lane_sreg
  import led_pkg::*;
#(
  parameter int GS_BITS = TLC_GS_BITS
) (
  input  logic               spiClk,
  input  logic               nReset,
  input  logic               load,
  input  logic               shift,
  input  logic               sdoEn,
  input  logic               ctrlEn,
  input  logic [GS_BITS-1:0] din,
  output logic               sdo
);

  logic [GS_BITS-1:0] q_r;
  logic [GS_BITS-1:0] qNext_s;
  logic               sdo_r;

  // Next shift-register contents.
  always_comb begin
    qNext_s = q_r;
    if (load) begin
      qNext_s = din;
    end else if (shift) begin
      qNext_s = {q_r[GS_BITS-2:0], 1'b0};
    end else begin
      qNext_s = q_r;
    end
  end

  // Shift register and SDO bit; SDO follows the MSB of the value the
  // register will hold, so it lines up with the state it is driven in.
  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      q_r   <= {GS_BITS{1'b0}};
      sdo_r <= 1'b0;
    end else begin
      q_r   <= qNext_s;
      sdo_r <= sdoEn ? qNext_s[GS_BITS-1] : (ctrlEn ? TLC_CTRL_BIT : 1'b0);
    end
  end

  assign sdo = sdo_r;

endmodule

// File: rtl/led_chain_shifter.sv
// ---------------------------------------------------------------------------
// led_chain_shifter
// Serialises one row of grayscale data from a ping-pong row buffer onto
// NUM_SHIFT parallel daisy-chained TLC5955-style lanes, then pulses LAT.
// Ports:
//   spiClk, nReset : clock, synchronous active-low reset
//   cmdStart       : start one row (ignored while busy)
//   bank, blank    : buffer bank / shift-zeros mode, sampled with cmdStart
//   cmdDone        : one-cycle pulse once the row is latched
//   busy           : row in progress (through the cmdDone cycle)
//   rdaddress      : {bank, word index} to the row buffer read port
//   rdData         : one word per lane, lane k at [k*GS_BITS +: GS_BITS]
//   SDO, SCLK, LAT : LED driver pins (all registered)
// rdData must be valid on the last of the RD_LATENCY cycles rdaddress is held.
// ---------------------------------------------------------------------------
module led_chain_shifter
  import led_pkg::*;
#(
  parameter int NUM_SHIFT   = 8,
  parameter int CHAIN_LEN   = 2,
  parameter int CH_PER_CHIP = TLC_CH_PER_CHIP,
  parameter int GS_BITS     = TLC_GS_BITS,
  parameter int RD_LATENCY  = 1,
  parameter int LAT_CYCLES  = 2
) (
  input  logic                                   spiClk,
  input  logic                                   nReset,
  input  logic                                   cmdStart,
  input  logic                                   bank,
  input  logic                                   blank,
  output logic                                   cmdDone,
  output logic                                   busy,
  output logic [$clog2(CHAIN_LEN*CH_PER_CHIP):0] rdaddress,
  input  logic [NUM_SHIFT*GS_BITS-1:0]           rdData,
  output logic [NUM_SHIFT-1:0]                   SDO,
  output logic                                   SCLK,
  output logic                                   LAT
);

  localparam int W  = CHAIN_LEN * CH_PER_CHIP;
  localparam int AW = $clog2(W);
  localparam int CW = (CH_PER_CHIP > 1) ? $clog2(CH_PER_CHIP) : 1;
  localparam int BW = $clog2(GS_BITS);
  localparam int FW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int LW = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;

  ledState_e      state_r, nextState_s;

  logic           bankLatched_r, bankNext_s;
  logic           blankLatched_r, blankNext_s;
  logic [AW-1:0]  wordCnt_r, wordNext_s;
  logic [CW-1:0]  chipPos_r, chipPosNext_s;   // word position within a chip
  logic [BW-1:0]  bitCnt_r, bitNext_s;
  logic [FW-1:0]  fetchCnt_r, fetchNext_s;
  logic [LW-1:0]  latCnt_r, latCntNext_s;

  logic           fetchLast_s, bitLast_s, wordLast_s, latLast_s, chipLast_s;
  logic           loadStrobe_s, shiftStrobe_s, sdoEn_s, ctrlEn_s;

  logic           sclkNext_s, latPinNext_s, busyNext_s, doneNext_s;
  logic           sclk_r, latPin_r, busy_r, cmdDone_r;
  logic [AW:0]    rdaddress_r;

  // Terminal-count decodes.
  always_comb begin
    fetchLast_s   = (fetchCnt_r == FW'(RD_LATENCY - 1));
    bitLast_s     = (bitCnt_r == BW'(GS_BITS - 1));
    wordLast_s    = (wordCnt_r == AW'(W - 1));
    latLast_s     = (latCnt_r == LW'(LAT_CYCLES - 1));
    chipLast_s    = (chipPos_r == CW'(CH_PER_CHIP - 1));
    loadStrobe_s  = (state_r == FETCH) && fetchLast_s;
    shiftStrobe_s = (state_r == BIT_HI);
  end

  // FSM state register.
  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmdStart) begin
          nextState_s = FETCH;
        end else begin
          nextState_s = IDLE;
        end
      end
      FETCH: begin
        if (!fetchLast_s) begin
          nextState_s = FETCH;
        end else if (chipPos_r == CW'(0)) begin
          nextState_s = CTRL_LO;   // first word of a chip carries a control bit
        end else begin
          nextState_s = BIT_LO;
        end
      end
      CTRL_LO: nextState_s = CTRL_HI;
      CTRL_HI: nextState_s = BIT_LO;
      BIT_LO:  nextState_s = BIT_HI;
      BIT_HI: begin
        if (!bitLast_s) begin
          nextState_s = BIT_LO;
        end else if (wordLast_s) begin
          nextState_s = LATCH;
        end else begin
          nextState_s = FETCH;
        end
      end
      LATCH: begin
        if (latLast_s) begin
          nextState_s = DONE;
        end else begin
          nextState_s = LATCH;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Next values of the row counters and the sampled mode bits.
  always_comb begin
    bankNext_s    = bankLatched_r;
    blankNext_s   = blankLatched_r;
    wordNext_s    = wordCnt_r;
    chipPosNext_s = chipPos_r;
    bitNext_s     = bitCnt_r;
    fetchNext_s   = fetchCnt_r;
    latCntNext_s  = latCnt_r;
    case (state_r)
      IDLE: begin
        if (cmdStart) begin
          bankNext_s    = bank;
          blankNext_s   = blank;
          wordNext_s    = AW'(0);
          chipPosNext_s = CW'(0);
          bitNext_s     = BW'(0);
          fetchNext_s   = FW'(0);
          latCntNext_s  = LW'(0);
        end else begin
          bankNext_s    = bankLatched_r;
        end
      end
      FETCH: fetchNext_s = fetchLast_s ? FW'(0) : (fetchCnt_r + FW'(1));
      BIT_HI: begin
        if (bitLast_s) begin
          bitNext_s = BW'(0);
          if (!wordLast_s) begin
            wordNext_s    = wordCnt_r + AW'(1);
            chipPosNext_s = chipLast_s ? CW'(0) : (chipPos_r + CW'(1));
          end else begin
            wordNext_s    = wordCnt_r;   // last word: hold, never wrap
          end
        end else begin
          bitNext_s = bitCnt_r + BW'(1);
        end
      end
      LATCH: latCntNext_s = latLast_s ? LW'(0) : (latCnt_r + LW'(1));
      default: begin
        fetchNext_s = fetchCnt_r;
      end
    endcase
  end

  // Row counters and mode bits.
  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      bankLatched_r  <= 1'b0;
      blankLatched_r <= 1'b0;
      wordCnt_r      <= AW'(0);
      chipPos_r      <= CW'(0);
      bitCnt_r       <= BW'(0);
      fetchCnt_r     <= FW'(0);
      latCnt_r       <= LW'(0);
    end else begin
      bankLatched_r  <= bankNext_s;
      blankLatched_r <= blankNext_s;
      wordCnt_r      <= wordNext_s;
      chipPos_r      <= chipPosNext_s;
      bitCnt_r       <= bitNext_s;
      fetchCnt_r     <= fetchNext_s;
      latCnt_r       <= latCntNext_s;
    end
  end

  // FSM output decode from the next state, so registered pins line up with
  // the state they belong to.
  always_comb begin
    sclkNext_s   = 1'b0;
    latPinNext_s = 1'b0;
    busyNext_s   = 1'b1;
    doneNext_s   = 1'b0;
    sdoEn_s      = 1'b0;
    ctrlEn_s     = 1'b0;
    case (nextState_s)
      IDLE:    busyNext_s = 1'b0;
      FETCH:   busyNext_s = 1'b1;
      CTRL_LO: ctrlEn_s   = 1'b1;
      CTRL_HI: begin
        ctrlEn_s   = 1'b1;
        sclkNext_s = 1'b1;
      end
      BIT_LO:  sdoEn_s    = 1'b1;
      BIT_HI: begin
        sdoEn_s    = 1'b1;
        sclkNext_s = 1'b1;
      end
      LATCH:   latPinNext_s = 1'b1;
      DONE:    doneNext_s   = 1'b1;
      default: busyNext_s   = 1'b0;
    endcase
  end

  // Registered control pins and read address.
  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      sclk_r      <= 1'b0;
      latPin_r    <= 1'b0;
      busy_r      <= 1'b0;
      cmdDone_r   <= 1'b0;
      rdaddress_r <= {(AW + 1){1'b0}};
    end else begin
      sclk_r      <= sclkNext_s;
      latPin_r    <= latPinNext_s;
      busy_r      <= busyNext_s;
      cmdDone_r   <= doneNext_s;
      rdaddress_r <= {bankNext_s, wordNext_s};
    end
  end

  for (genvar k = 0; k < NUM_SHIFT; k++) begin : gLane
    led_lane_sreg #(
      .GS_BITS (GS_BITS)
    ) uLane (
      .spiClk (spiClk),
      .nReset (nReset),
      .load   (loadStrobe_s),
      .shift  (shiftStrobe_s),
      .sdoEn  (sdoEn_s),
      .ctrlEn (ctrlEn_s),
      .din    (blankLatched_r ? {GS_BITS{1'b0}} : rdData[k*GS_BITS +: GS_BITS]),
      .sdo    (SDO[k])
    );
  end

  led_chain_shifter_chk #(
    .CHAIN_LEN   (CHAIN_LEN),
    .CH_PER_CHIP (CH_PER_CHIP),
    .GS_BITS     (GS_BITS),
    .RD_LATENCY  (RD_LATENCY),
    .LAT_CYCLES  (LAT_CYCLES)
  ) uChk (
    .spiClk   (spiClk),
    .nReset   (nReset),
    .cmdStart (cmdStart),
    .busy     (busy_r),
    .cmdDone  (cmdDone_r),
    .SCLK     (sclk_r),
    .LAT      (latPin_r)
  );

  assign SCLK      = sclk_r;
  assign LAT       = latPin_r;
  assign busy      = busy_r;
  assign cmdDone   = cmdDone_r;
  assign rdaddress = rdaddress_r;

endmodule

// File: tb/tb_led_chain_shifter.sv
// ---------------------------------------------------------------------------
// tb_led_chain_shifter
// Two instances: A (1 chip of 2 channels, RD_LATENCY=1, combinational buffer
// read) and B (2 chips of 2 channels, RD_LATENCY=2, registered buffer read).
// Expected serial bits are pushed to a per-instance queue when a row is
// started and popped at every SCLK rising edge.
// ---------------------------------------------------------------------------
module tb_led_chain_shifter;
  import led_pkg::*;

  localparam int NS = 2;
  localparam int GS = 16;
  localparam int CHA = 1, CPA = 2, RDA = 1, LTA = 2, WA = CHA * CPA, AWA = 1;
  localparam int CHB = 2, CPB = 2, RDB = 2, LTB = 2, WB = CHB * CPB, AWB = 2;

  logic spiClk = 1'b0;
  always #5 spiClk = ~spiClk;

  logic nResetA, cmdStartA, bankA, blankA, cmdDoneA, busyA, sclkA, latA;
  logic [AWA:0] rdaddressA;
  logic [NS*GS-1:0] rdDataA;
  logic [NS-1:0] sdoA;
  logic nResetB, cmdStartB, bankB, blankB, cmdDoneB, busyB, sclkB, latB;
  logic [AWB:0] rdaddressB;
  logic [NS*GS-1:0] rdDataB;
  logic [NS-1:0] sdoB;

  logic [31:0] memA [4];
  logic [31:0] memB [8];

  assign rdDataA = memA[rdaddressA];           // data valid in the address cycle
  always @(posedge spiClk) rdDataB <= memB[rdaddressB];  // one extra cycle

  led_chain_shifter #(.NUM_SHIFT(NS), .CHAIN_LEN(CHA), .CH_PER_CHIP(CPA),
    .GS_BITS(GS), .RD_LATENCY(RDA), .LAT_CYCLES(LTA)) dutA (
    .spiClk(spiClk), .nReset(nResetA), .cmdStart(cmdStartA), .bank(bankA),
    .blank(blankA), .cmdDone(cmdDoneA), .busy(busyA), .rdaddress(rdaddressA),
    .rdData(rdDataA), .SDO(sdoA), .SCLK(sclkA), .LAT(latA));

  led_chain_shifter #(.NUM_SHIFT(NS), .CHAIN_LEN(CHB), .CH_PER_CHIP(CPB),
    .GS_BITS(GS), .RD_LATENCY(RDB), .LAT_CYCLES(LTB)) dutB (
    .spiClk(spiClk), .nReset(nResetB), .cmdStart(cmdStartB), .bank(bankB),
    .blank(blankB), .cmdDone(cmdDoneB), .busy(busyB), .rdaddress(rdaddressB),
    .rdData(rdDataB), .SDO(sdoB), .SCLK(sclkB), .LAT(latB));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [NS-1:0] qA[$];
  logic [NS-1:0] qB[$];
  int edgesA = 0, latHighA = 0, edgesB = 0, latHighB = 0;
  logic prevSclkA = 1'b0, prevSclkB = 1'b0;

  // Monitor A: pop one expected bit vector per SCLK rising edge.
  always @(negedge spiClk) begin
    if (sclkA && !prevSclkA) begin
      edgesA++;
      check("sdoA_queue_nonempty", qA.size() != 0, 1'b1);
      if (qA.size() != 0) check("sdoA_bit", sdoA, qA.pop_front());
    end
    prevSclkA = sclkA;
    if (latA) latHighA++;
    if (sclkA || latA) check("sclk_lat_exclusiveA", sclkA & latA, 1'b0);
  end

  // Monitor B.
  always @(negedge spiClk) begin
    if (sclkB && !prevSclkB) begin
      edgesB++;
      check("sdoB_queue_nonempty", qB.size() != 0, 1'b1);
      if (qB.size() != 0) check("sdoB_bit", sdoB, qB.pop_front());
    end
    prevSclkB = sclkB;
    if (latB) latHighB++;
    if (sclkB || latB) check("sclk_lat_exclusiveB", sclkB & latB, 1'b0);
  end

  // Reference model of one row: control bit 0 before each chip, then every
  // word MSB first, lane k in SDO bit k.
  task automatic pushExp(input int id, input logic bk, input logic bl);
    logic [31:0] d;
    int w, cp;
    w  = (id == 0) ? WA : WB;
    cp = (id == 0) ? CPA : CPB;
    for (int i = 0; i < w; i++) begin
      if (i % cp == 0) begin
        if (id == 0) qA.push_back(2'b00); else qB.push_back(2'b00);
      end
      if (bl) d = 32'd0;
      else if (id == 0) d = memA[bk * WA + i];
      else d = memB[bk * WB + i];
      for (int b = GS - 1; b >= 0; b--) begin
        if (id == 0) qA.push_back({d[GS + b], d[b]});
        else qB.push_back({d[GS + b], d[b]});
      end
    end
  endtask

  // Run one row; rep1/rep2 re-pulse cmdStart, rstAt pulls nReset low (A only).
  task automatic runRow(input int id, input logic bk, input logic bl, input int rep1,
                        input int rep2, input int rstAt, input int expDone,
                        input int expEdges, input int expLat);
    int n, doneAt, doneCnt;
    logic bankBad, busyNow, doneNow, abit;
    pushExp(id, bk, bl);
    if (id == 0) begin
      edgesA = 0; latHighA = 0; bankA = bk; blankA = bl; cmdStartA = 1'b1;
    end else begin
      edgesB = 0; latHighB = 0; bankB = bk; blankB = bl; cmdStartB = 1'b1;
    end
    n = 0; doneAt = -1; doneCnt = 0; bankBad = 1'b0;
    while (n < expDone + 20) begin
      @(negedge spiClk);
      n++;
      if (id == 0) begin
        busyNow = busyA; doneNow = cmdDoneA; abit = rdaddressA[AWA];
      end else begin
        busyNow = busyB; doneNow = cmdDoneB; abit = rdaddressB[AWB];
      end
      if (busyNow && (abit !== bk)) bankBad = 1'b1;
      if (doneNow) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      if (rstAt < 0 && n == 1) check("busy_after_start", busyNow, 1'b1);
      if (rstAt < 0 && n == expDone + 1) check("busy_after_done", busyNow, 1'b0);
      if (rstAt >= 0 && n == rstAt + 1) begin
        check("rst_sclk", sclkA, 1'b0);
        check("rst_lat", latA, 1'b0);
        check("rst_sdo", sdoA, 2'b00);
        check("rst_busy", busyA, 1'b0);
        check("rst_rdaddress", rdaddressA, 2'b00);
      end
      if (id == 0) begin
        cmdStartA = (n == rep1) || (n == rep2);
        nResetA   = !(n == rstAt);
      end else begin
        cmdStartB = (n == rep1) || (n == rep2);
      end
    end
    if (rstAt < 0) begin
      check("done_cycle", doneAt, expDone);
      check("done_count", doneCnt, 1);
      check("sclk_edges", (id == 0) ? edgesA : edgesB, expEdges);
      check("lat_cycles", (id == 0) ? latHighA : latHighB, expLat);
      check("queue_drained", (id == 0) ? qA.size() : qB.size(), 0);
      check("rdaddress_bank", bankBad, 1'b0);
    end else begin
      check("abort_no_done", doneCnt, 0);
      check("abort_no_lat", latHighA, 0);
      qA.delete();
    end
  endtask

  typedef struct {
    logic bank;
    logic blank;
    int   expDone;
    int   expEdges;
    int   expLat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 71, 33, 2};
    vecs[1] = '{1'b1, 1'b0, 71, 33, 2};
    vecs[2] = '{1'b0, 1'b1, 71, 33, 2};
    vecs[3] = '{1'b1, 1'b1, 71, 33, 2};

    memA[0] = {16'h0001, 16'hA5C3};
    memA[1] = {16'h0001, 16'hA5C3};
    memA[2] = {16'hFEDC, 16'h1234};
    memA[3] = {16'h7FFE, 16'h8001};
    memB[0] = {16'h8000, 16'h0F0F};
    memB[1] = {16'h00FF, 16'hF00D};
    memB[2] = {16'hBEEF, 16'h1357};
    memB[3] = {16'hCAFE, 16'h2468};
    memB[4] = 32'hFFFF_FFFF;
    memB[5] = 32'h0000_FFFF;
    memB[6] = 32'h8000_0001;
    memB[7] = 32'h5555_AAAA;

    nResetA = 1'b0; cmdStartA = 1'b0; bankA = 1'b0; blankA = 1'b0;
    nResetB = 1'b0; cmdStartB = 1'b0; bankB = 1'b0; blankB = 1'b0;
    repeat (3) @(negedge spiClk);
    check("reset_busyA", busyA, 1'b0);
    check("reset_doneA", cmdDoneA, 1'b0);
    check("reset_pinsA", {sclkA, latA, sdoA}, 4'b0000);
    check("reset_addrA", rdaddressA, 2'b00);
    check("reset_pinsB", {busyB, cmdDoneB, sclkB, latB, sdoB}, 6'b000000);
    nResetA = 1'b1; nResetB = 1'b1;
    repeat (2) @(negedge spiClk);
    check("idle_busyA", busyA, 1'b0);

    for (int i = 0; i < 4; i++)
      runRow(0, vecs[i].bank, vecs[i].blank, -1, -1, -1,
             vecs[i].expDone, vecs[i].expEdges, vecs[i].expLat);

    // cmdStart re-pulsed mid-row must be ignored.
    runRow(0, 1'b0, 1'b0, 10, 40, -1, 71, 33, 2);
    // Abort at cycle 30, then a clean full row.
    runRow(0, 1'b1, 1'b0, -1, -1, 30, 71, 0, 0);
    runRow(0, 1'b0, 1'b0, -1, -1, -1, 71, 33, 2);

    // Two chips, two-cycle read latency.
    runRow(1, 1'b0, 1'b0, -1, -1, -1, 143, 66, 2);
    runRow(1, 1'b1, 1'b0, -1, -1, -1, 143, 66, 2);
    runRow(1, 1'b1, 1'b1, -1, -1, -1, 143, 66, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_chain_shifter.md
Name: led_chain_shifter

Overview:
- Parametrised next-generation LED shift-out engine. It serialises one row of grayscale data from a ping-pong row buffer onto NUM_SHIFT parallel daisy-chained TLC5955-style lanes, then pulses LAT.
- Generalised over lane count, chain length, channels per chip and buffer read latency.
- Adds two modes: double-buffer bank select and a blank mode that shifts zeros without touching the buffer.
- Sits entirely in the spiClk domain, between the row buffer read port and the LED driver pins.

Parameters:
- NUM_SHIFT, 8: number of parallel serial lanes (SDO width).
- CHAIN_LEN, 2: chips daisy-chained per lane.
- CH_PER_CHIP, 48: grayscale words per chip.
- GS_BITS, 16: bits per grayscale word, shifted MSB first.
- RD_LATENCY, 1: row-buffer read latency in spiClk cycles (1 or 2).
- LAT_CYCLES, 2: LAT high width in spiClk cycles.
- Derived: W = CHAIN_LEN*CH_PER_CHIP words per lane; B = CHAIN_LEN*(1+CH_PER_CHIP*GS_BITS) bits per lane; AW = $clog2(W).

Ports:
- spiClk  in  1  clock.
- nReset  in  1  synchronous active-low reset.
- cmdStart  in  1  single-cycle start request.
- bank  in  1  row-buffer bank to read; sampled with cmdStart.
- blank  in  1  shift all-zero grayscale; sampled with cmdStart.
- cmdDone  out  1  single-cycle pulse when the row is latched.
- busy  out  1  high from the cycle after the accepted cmdStart through the cmdDone cycle.
- rdaddress  out  AW+1  {bank, word index} to the buffer read port.
- rdData  in  NUM_SHIFT*GS_BITS  one word per lane; lane k = bits [k*GS_BITS +: GS_BITS].
- SDO  out  NUM_SHIFT  serial data, one bit per lane.
- SCLK  out  1  shift clock.
- LAT  out  1  latch.

Behaviour:
- Reset: applies on any cycle, including mid-row. Forces state IDLE and drives cmdDone, busy, SDO, SCLK and LAT to 0, rdaddress to 0, and all counters to 0. No LAT pulse is issued for an aborted row.
- IDLE: cmdStart=1 latches bank and blank, clears the word and chip counters, and enters FETCH. cmdStart while busy is ignored.
- FETCH: lasts RD_LATENCY cycles, with rdaddress={bankLatched, word} held throughout. On the last cycle, rdData is loaded into the per-lane shift registers (or zeros if blank). Next state:
  - CTRL_LO if word % CH_PER_CHIP == 0;
  - otherwise BIT_LO.
  - In blank mode FETCH is still timed identically, so row timing is mode-independent.
- CTRL_LO / CTRL_HI: shift one control bit of value 0 on all lanes at the start of each chip's data. SCLK=0 in CTRL_LO and SCLK=1 in CTRL_HI; SDO is held stable across both. CTRL_HI goes to BIT_LO.
- BIT_LO / BIT_HI: SDO[k] = MSB of lane k's shift register, with SCLK=0 in BIT_LO and SCLK=1 in BIT_HI. The register shifts left on exit from BIT_HI. After GS_BITS bits:
  - if word == W-1, enter LATCH;
  - otherwise increment word and enter FETCH.
- LATCH: SCLK=0, SDO=0, LAT=1 for LAT_CYCLES cycles, then DONE.
- DONE: cmdDone=1 and busy=1 for one cycle, then IDLE with busy=0.
- Outputs are registered; SDO changes only when SCLK is 0 (setup of half an SCLK period).
- Timing: cmdDone asserts exactly 1 + 2*B + W*RD_LATENCY + LAT_CYCLES cycles after the cycle cmdStart is sampled.
- Word counter width is AW; it never wraps within a row. The counter returns to 0 on IDLE exit.
- SCLK and LAT are never high together.

Decomposition:
- Package led_pkg holds:
  - the state enum (IDLE, FETCH, CTRL_LO, CTRL_HI, BIT_LO, BIT_HI, LATCH, DONE);
  - TLC5955 constants: default CH_PER_CHIP=48, GS_BITS=16, control bit value 0;
  - a function computing the row cycle count, shared by the RTL assertions and the bench.
- Sub-module led_lane_sreg: a GS_BITS parallel-load, MSB-first shift register, instantiated NUM_SHIFT times via generate. The FSM and counters stay in the top level.

Test Plan:
- Small configuration (NUM_SHIFT=2, CHAIN_LEN=1, CH_PER_CHIP=2, GS_BITS=16, RD_LATENCY=1, LAT_CYCLES=2); buffer lane0=16'hA5C3, lane1=16'h0001 for both words. Pulse cmdStart, bank=0 -> captured SDO[0] on SCLK rising edges = 0, A5C3, A5C3 (33 bits); SDO[1] = 0, 0001, 0001; 33 SCLK rising edges; LAT high 2 cycles; cmdDone 71 cycles after cmdStart.
- Same configuration with bank=1 -> rdaddress MSB=1 on every fetch; bank-1 data shifted; bank-0 data never seen.
- blank=1 with a non-zero buffer -> all 33 bits are 0 on every lane; cmdDone still at cycle 71.
- cmdStart re-pulsed at cycles 10 and 40 of a row -> both ignored; exactly one cmdDone; next cmdStart after IDLE is accepted.
- nReset low at cycle 30 mid-row -> next cycle SCLK=LAT=SDO=busy=0; no LAT pulse or cmdDone; a following cmdStart runs a full 71-cycle row.
- RD_LATENCY=2, CHAIN_LEN=2 -> control bit inserted before word 0 and word 2; B=66; cmdDone at 1+132+8+2=143 cycles.
